// File: rtl/eth_pkg.sv
// Shared types for the eth_sw ingress path: beat layout and arbiter state encoding.
package eth_pkg;

    localparam int DATA_W = 64;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              vld;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester after last_grant, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; grant is only a suggestion until the caller registers it.
module rr_pick
    import eth_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             any_grant
);

    int idx;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        // i runs 1..N so last_grant itself is considered last
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_grant) + i) % N;
            if (!any_grant && req[idx]) begin
                grant     = IDX_W'(idx);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_pkt_arbiter.sv
// Packet-granular round-robin mux of NUM_PORTS beat streams onto one eth_sw ingress.
// Latency: accepted beat appears on out_* one cycle later; one arbitration cycle per packet.
// Backpressure: only the granted port sees in_rdy; no backpressure from eth_sw.
module eth_pkt_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_W        = eth_pkg::DATA_W,
    parameter int MAX_PKT_BEATS = 256
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]          in_sop,
    input  logic [NUM_PORTS-1:0]          in_eop,
    input  logic [NUM_PORTS-1:0]          in_vld,
    output logic [NUM_PORTS-1:0]          in_rdy,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic                          out_vld,
    output logic [$clog2(NUM_PORTS)-1:0]  out_port,
    output logic                          pkt_trunc,
    output logic                          sop_err,
    output logic [15:0]                   drop_cnt
);

    import eth_pkg::*;

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PKT_BEATS);
    localparam logic [PW-1:0] LAST_RST = PW'(NUM_PORTS - 1);

    state_t              state_q, state_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic [PW-1:0]       last_grant_q, last_grant_d;
    logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic                out_vld_q, out_vld_d;
    logic [PW-1:0]       out_port_q, out_port_d;
    logic                pkt_trunc_q, pkt_trunc_d;
    logic                sop_err_q, sop_err_d;

    logic [DATA_W-1:0]   port_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] sop_req;
    logic [NUM_PORTS-1:0] stray;
    logic [PW-1:0]       pick;
    logic                pick_vld;
    logic                g_vld, g_sop, g_eop;
    logic [CW-1:0]       cnt_next;
    logic                first_beat;
    logic                force_eop;
    logic [PW:0]         stray_cnt;
    logic [16:0]         drop_sum;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign port_data[p] = in_data[p*DATA_W +: DATA_W];
    end

    assign sop_req = in_vld & in_sop;
    assign stray   = in_vld & ~in_sop;

    rr_pick #(
        .N     (NUM_PORTS),
        .IDX_W (PW)
    ) u_rr_pick (
        .req        (sop_req),
        .last_grant (last_grant_q),
        .grant      (pick),
        .any_grant  (pick_vld)
    );

    assign g_vld      = in_vld[grant_q];
    assign g_sop      = in_sop[grant_q];
    assign g_eop      = in_eop[grant_q];
    assign cnt_next   = beat_cnt_q + CW'(1);
    assign first_beat = (beat_cnt_q == '0);
    // The beat that reaches the limit closes the packet unless it already does
    assign force_eop  = (cnt_next == MAX_CNT) && !g_eop;

    always_comb begin
        stray_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            stray_cnt = stray_cnt + (PW+1)'(stray[p]);
        end
    end

    assign drop_sum = {1'b0, drop_cnt_q} + 17'(stray_cnt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) state_d = XFER;
            end
            XFER: begin
                if (g_vld) begin
                    if (g_eop)          state_d = IDLE;
                    else if (force_eop) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (g_vld && g_eop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_rdy       = '0;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        out_data_d   = '0;
        out_sop_d    = 1'b0;
        out_eop_d    = 1'b0;
        out_vld_d    = 1'b0;
        out_port_d   = '0;
        pkt_trunc_d  = 1'b0;
        sop_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // SOP beats wait for XFER; everything else is swallowed and counted
                in_rdy     = stray;
                beat_cnt_d = '0;
                drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                if (pick_vld) grant_d = pick;
            end
            XFER: begin
                in_rdy[grant_q] = 1'b1;
                if (g_vld) begin
                    beat_cnt_d  = cnt_next;
                    out_vld_d   = 1'b1;
                    out_data_d  = port_data[grant_q];
                    out_sop_d   = g_sop && first_beat;
                    out_eop_d   = g_eop || force_eop;
                    out_port_d  = grant_q;
                    pkt_trunc_d = force_eop;
                    sop_err_d   = g_sop && !first_beat;
                    if (g_eop || force_eop) last_grant_d = grant_q;
                end
            end
            DRAIN: begin
                in_rdy[grant_q] = 1'b1;
            end
            default: ;
        endcase
        if (reset) in_rdy = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            beat_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            out_data_q   <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_port_q   <= '0;
            pkt_trunc_q  <= 1'b0;
            sop_err_q    <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            out_data_q   <= out_data_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_vld_q    <= out_vld_d;
            out_port_q   <= out_port_d;
            pkt_trunc_q  <= pkt_trunc_d;
            sop_err_q    <= sop_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_vld   = out_vld_q;
    assign out_port  = out_port_q;
    assign pkt_trunc = pkt_trunc_q;
    assign sop_err   = sop_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_eth_pkt_arbiter.sv
// Directed bench for eth_pkt_arbiter with per-port beat queues and an output log.
module tb_eth_pkt_arbiter;

    localparam int NP   = 4;
    localparam int DW   = 64;
    localparam int MAXB = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     in_sop, in_eop, in_vld, in_rdy;
    logic [DW-1:0]     out_data;
    logic              out_sop, out_eop, out_vld;
    logic [1:0]        out_port;
    logic              pkt_trunc, sop_err;
    logic [15:0]       drop_cnt;

    eth_pkt_arbiter #(
        .NUM_PORTS     (NP),
        .DATA_W        (DW),
        .MAX_PKT_BEATS (MAXB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_vld   (out_vld),
        .out_port  (out_port),
        .pkt_trunc (pkt_trunc),
        .sop_err   (sop_err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW+1:0] mem [NP][64];
    int            hd [NP];
    int            tl [NP];

    logic [DW-1:0] o_data  [64];
    logic          o_sop   [64];
    logic          o_eop   [64];
    logic          o_trunc [64];
    int            o_port  [64];
    int            o_cyc   [64];
    int            n_out;
    int            n_sop_err;

    task automatic push(input int p, input logic [DW-1:0] d, input logic s, input logic e);
        mem[p][tl[p]] = {s, e, d};
        tl[p]++;
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (hd[p] < tl[p]) begin
                in_vld[p] = 1'b1;
                {in_sop[p], in_eop[p], in_data[p*DW +: DW]} = mem[p][hd[p]];
            end else begin
                in_vld[p] = 1'b0;
                in_sop[p] = 1'b0;
                in_eop[p] = 1'b0;
                in_data[p*DW +: DW] = '0;
            end
        end
    endtask

    // Handshakes are sampled on the falling edge; inputs change 1 time unit after the rising edge.
    task automatic cycle();
        logic [NP-1:0] acc;
        @(negedge clock);
        acc = in_vld & in_rdy;
        @(posedge clock);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) if (acc[p]) hd[p]++;
        drive();
        if (out_vld && n_out < 64) begin
            o_data[n_out]  = out_data;
            o_sop[n_out]   = out_sop;
            o_eop[n_out]   = out_eop;
            o_trunc[n_out] = pkt_trunc;
            o_port[n_out]  = int'(out_port);
            o_cyc[n_out]   = cyc;
            n_out++;
        end
        if (sop_err) n_sop_err++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic start();
        n_out     = 0;
        n_sop_err = 0;
        for (int p = 0; p < NP; p++) begin
            hd[p] = 0;
            tl[p] = 0;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        in_data = '0;
        in_sop  = '0;
        in_eop  = '0;
        in_vld  = 4'b0010;
        #2 reset = 1'b1;
        #10;
        n_tests++;
        if (in_rdy !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_in_rdy: got %b want 0000", in_rdy);
        end
        n_tests++;
        if ({out_vld, out_sop, out_eop, pkt_trunc, sop_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got vld/sop/eop/trunc/err %b want 00000",
                     {out_vld, out_sop, out_eop, pkt_trunc, sop_err});
        end
        n_tests++;
        if (out_data !== '0 || out_port !== 2'd0 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: got data %0h port %0d drop %0d want 0 0 0",
                     out_data, out_port, drop_cnt);
        end
        in_vld = '0;
        @(posedge clock);
        #1 reset = 1'b0;
        start();
        drive();
    endtask

    task automatic test_round_robin();
        start();
        for (int p = 0; p < NP; p++) begin
            push(p, DW'(p*256 + 1), 1'b1, 1'b0);
            push(p, DW'(p*256 + 2), 1'b0, 1'b1);
        end
        run(20);
        n_tests++;
        if (n_out !== 8) begin
            n_fail++;
            $display("FAIL rr_count: got %0d beats want 8", n_out);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (o_port[i] !== i/2 || o_data[i] !== DW'((i/2)*256 + (i%2) + 1) ||
                o_sop[i] !== (i%2 == 0) || o_eop[i] !== (i%2 == 1)) begin
                n_fail++;
                $display("FAIL rr_beat%0d: got port %0d data %0h sop %0b eop %0b want port %0d data %0h sop %0b eop %0b",
                         i, o_port[i], o_data[i], o_sop[i], o_eop[i],
                         i/2, (i/2)*256 + (i%2) + 1, (i%2 == 0), (i%2 == 1));
            end
            if (i > 0) begin
                n_tests++;
                if (o_cyc[i] - o_cyc[i-1] !== ((i%2 == 1) ? 1 : 2)) begin
                    n_fail++;
                    $display("FAIL rr_spacing%0d: got %0d cycles want %0d",
                             i, o_cyc[i] - o_cyc[i-1], (i%2 == 1) ? 1 : 2);
                end
            end
        end
    endtask

    task automatic test_single_port();
        int c0;
        start();
        c0 = cyc;
        for (int i = 0; i < 4; i++) push(0, DW'(i + 1), i == 0, i == 3);
        run(10);
        n_tests++;
        if (n_out !== 4 || o_cyc[0] !== c0 + 3) begin
            n_fail++;
            $display("FAIL single_port_timing: got %0d beats first at +%0d want 4 beats first at +3",
                     n_out, o_cyc[0] - c0);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (o_port[i] !== 0 || o_data[i] !== DW'(i + 1) || o_sop[i] !== (i == 0) ||
                o_eop[i] !== (i == 3) || o_cyc[i] !== o_cyc[0] + i) begin
                n_fail++;
                $display("FAIL single_port_beat%0d: got port %0d data %0h sop %0b eop %0b cyc +%0d want port 0 data %0h sop %0b eop %0b cyc +%0d",
                         i, o_port[i], o_data[i], o_sop[i], o_eop[i], o_cyc[i] - o_cyc[0],
                         i + 1, (i == 0), (i == 3), i);
            end
        end
    endtask

    task automatic test_stray();
        start();
        for (int i = 0; i < 3; i++) push(1, DW'(64'hA0 + i), 1'b0, 1'b0);
        run(4);
        n_tests++;
        if (hd[1] !== 3 || n_out !== 0 || drop_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL stray_drop: got consumed %0d out %0d drop %0d want 3 0 3",
                     hd[1], n_out, drop_cnt);
        end
        start();
        push(0, DW'(64'hB0), 1'b0, 1'b0);
        push(2, DW'(64'hB2), 1'b0, 1'b0);
        run(2);
        n_tests++;
        if (drop_cnt !== 16'd5 || n_out !== 0) begin
            n_fail++;
            $display("FAIL stray_popcount: got drop %0d out %0d want 5 0", drop_cnt, n_out);
        end
    endtask

    task automatic test_single_beat();
        start();
        push(3, DW'(64'hDEADBEEF), 1'b1, 1'b1);
        run(6);
        n_tests++;
        if (n_out !== 1 || o_port[0] !== 3 || o_data[0] !== DW'(64'hDEADBEEF) ||
            o_sop[0] !== 1'b1 || o_eop[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_beat: got n %0d port %0d data %0h sop %0b eop %0b want 1 3 deadbeef 1 1",
                     n_out, o_port[0], o_data[0], o_sop[0], o_eop[0]);
        end
        push(0, DW'(64'h55), 1'b0, 1'b0);
        run(3);
        n_tests++;
        if (drop_cnt !== 16'd6 || n_out !== 1) begin
            n_fail++;
            $display("FAIL single_beat_idle: got drop %0d out %0d want 6 1", drop_cnt, n_out);
        end
    endtask

    task automatic test_trunc();
        start();
        for (int i = 0; i < 12; i++) push(2, DW'(64'h20 + i), i == 0, i == 11);
        run(3);
        push(1, DW'(64'h77), 1'b1, 1'b1);
        run(25);
        n_tests++;
        if (n_out !== 9 || hd[2] !== 12 || drop_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL trunc_count: got out %0d consumed %0d drop %0d want 9 12 6",
                     n_out, hd[2], drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (o_port[i] !== 2 || o_data[i] !== DW'(64'h20 + i) || o_sop[i] !== (i == 0) ||
                o_eop[i] !== (i == 7) || o_trunc[i] !== (i == 7)) begin
                n_fail++;
                $display("FAIL trunc_beat%0d: got port %0d data %0h sop %0b eop %0b trunc %0b want port 2 data %0h sop %0b eop %0b trunc %0b",
                         i, o_port[i], o_data[i], o_sop[i], o_eop[i], o_trunc[i],
                         32'h20 + i, (i == 0), (i == 7), (i == 7));
            end
        end
        n_tests++;
        if (o_port[8] !== 1 || o_data[8] !== DW'(64'h77) || o_cyc[8] !== o_cyc[0] + 13) begin
            n_fail++;
            $display("FAIL trunc_next_grant: got port %0d data %0h at +%0d want port 1 data 77 at +13",
                     o_port[8], o_data[8], o_cyc[8] - o_cyc[0]);
        end
    endtask

    task automatic test_sop_err();
        start();
        push(0, DW'(64'h31), 1'b1, 1'b0);
        push(0, DW'(64'h32), 1'b1, 1'b0);
        push(0, DW'(64'h33), 1'b0, 1'b1);
        run(8);
        n_tests++;
        if (n_out !== 3 || o_sop[0] !== 1'b1 || o_sop[1] !== 1'b0 || o_data[1] !== DW'(64'h32) ||
            o_eop[2] !== 1'b1 || n_sop_err !== 1) begin
            n_fail++;
            $display("FAIL sop_err: got n %0d sop0 %0b sop1 %0b data1 %0h eop2 %0b pulses %0d want 3 1 0 32 1 1",
                     n_out, o_sop[0], o_sop[1], o_data[1], o_eop[2], n_sop_err);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        start();
        for (int i = 0; i < 5; i++) push(0, DW'(64'h41 + i), i == 0, i == 4);
        guard = 0;
        while (n_out < 2 && guard < 20) begin
            cycle();
            guard++;
        end
        n_tests++;
        if (n_out < 2) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got %0d beats want 2 within 20 cycles", n_out);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (out_vld !== 1'b0 || in_rdy !== 4'b0000 || out_eop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got vld %0b rdy %b eop %0b want 0 0000 0",
                     out_vld, in_rdy, out_eop);
        end
        start();
        drive();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        push(2, DW'(64'h52), 1'b1, 1'b1);
        push(0, DW'(64'h50), 1'b1, 1'b1);
        run(10);
        n_tests++;
        if (n_out !== 2 || o_port[0] !== 0 || o_port[1] !== 2 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_regrant: got n %0d ports %0d,%0d drop %0d want 2 0,2 0",
                     n_out, o_port[0], o_port[1], drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_port();
        test_stray();
        test_single_beat();
        test_trunc();
        test_sop_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/eth_pkt_arbiter.md
Name: eth_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that multiplexes NUM_PORTS 64-bit SOP/EOP/valid packet streams onto the single ingress of the eth_sw switch.
- A grant is held from SOP through EOP, so packets never interleave.
- Enforces a maximum packet length: over-long packets are truncated with a forced EOP, and their remainder is drained.
- Discards stray beats that arrive outside a packet and counts them.

Parameters:
NUM_PORTS, 4, number of requesting ports (2..8)
DATA_W, 64, beat width; matches eth_sw DATAIN/DATAOUT
MAX_PKT_BEATS, 256, beat limit per packet; the beat that reaches this limit is forced to EOP

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_data  in  NUM_PORTS*DATA_W  packed beat data; port p occupies bits [p*DATA_W +: DATA_W]
in_sop  in  NUM_PORTS  start-of-packet flag per port
in_eop  in  NUM_PORTS  end-of-packet flag per port
in_vld  in  NUM_PORTS  beat valid per port
in_rdy  out  NUM_PORTS  beat accepted this cycle when in_vld[p] & in_rdy[p]
out_data  out  DATA_W  to eth_sw DATAIN
out_sop  out  1  to eth_sw inSOP
out_eop  out  1  to eth_sw inEOP
out_vld  out  1  to eth_sw vld
out_port  out  $clog2(NUM_PORTS)  source port of the current output beat
pkt_trunc  out  1  one-cycle pulse on a forced-EOP beat
sop_err  out  1  one-cycle pulse when an SOP arrives inside a packet
drop_cnt  out  16  saturating count of discarded stray beats

Behaviour:
- Reset (async assert, sync deassert by clock): state=IDLE, last_grant=NUM_PORTS-1, beat_cnt=0, drop_cnt=0.
- Reset values of outputs: all out_* = 0, in_rdy = 0, pkt_trunc = 0, sop_err = 0.
- States: IDLE, XFER, DRAIN.
- IDLE, grant selection:
  - Candidates are ports with in_vld & in_sop.
  - Pick the first candidate searching from last_grant+1 modulo NUM_PORTS.
  - Register grant g; move to XFER next cycle.
  - The SOP beat is not consumed in IDLE: in_rdy[g] stays 0.
- IDLE, stray beats:
  - A port with in_vld & ~in_sop gets in_rdy=1; the beat is discarded.
  - drop_cnt increments by 1 per such beat; several in one cycle add their popcount.
  - drop_cnt saturates at 0xFFFF.
- XFER, handshake:
  - in_rdy[g]=1; all other in_rdy=0; a non-granted port keeps its data stable.
  - Each accepted beat appears one cycle later on out_data/out_sop/out_eop with out_vld=1 and out_port=g.
  - out_vld=0 when no beat was accepted; there is no backpressure from eth_sw.
- XFER, beat counting:
  - beat_cnt counts accepted beats starting at 1 for the SOP beat.
  - The EOP beat sets last_grant=g and returns to IDLE.
  - Arbitration for the next packet occurs in that IDLE cycle, so the minimum gap between packets is 1 idle output cycle.
- Single-beat packet (SOP & EOP on the same beat): output has out_sop=out_eop=1; return to IDLE.
- SOP on a non-first beat within XFER: beat forwarded with out_sop forced to 0; sop_err pulses; the packet continues.
- Truncation:
  - When beat_cnt==MAX_PKT_BEATS and the beat lacks EOP, it is emitted with out_eop=1 and pkt_trunc pulses.
  - last_grant=g; go to DRAIN.
- DRAIN:
  - in_rdy[g]=1; beats are discarded with no output and no drop_cnt change.
  - Return to IDLE after the EOP beat.
- Reset mid-packet: outputs drop to 0 immediately with no EOP emitted; eth_sw reset is the responsibility of the top level.
- beat_cnt width is $clog2(MAX_PKT_BEATS+1); it never wraps.

Decomposition:
- Package eth_pkg holds:
  - DATA_W
  - the typedef for the {data, sop, eop, vld} beat struct
  - the state enum {IDLE, XFER, DRAIN}
- Sub-module rr_pick (combinational): request vector + last_grant -> grant index + any_grant.
- The FSM, counters and output register stay in eth_pkt_arbiter.

Test Plan:
- Port 0 sends a 4-beat packet, data 0x1..0x4 -> out beats 0x1..0x4, 1 cycle later, out_sop on 0x1, out_eop on 0x4, out_port=0.
- Ports 0..3 all assert SOP at once, each with a 2-beat packet -> output order 0,1,2,3; 1 idle cycle between packets; no interleave.
- MAX_PKT_BEATS=8, port 2 sends 12 beats -> out_eop and pkt_trunc on beat 8; beats 9..12 absent; next grant only after port 2's EOP.
- In IDLE, port 1 drives 3 beats with in_vld=1, in_sop=0 -> in_rdy[1]=1 each cycle, no output, drop_cnt=3.
- Port 3 sends a single beat with SOP=EOP, data 0xDEADBEEF -> one out beat with out_sop=out_eop=1, FSM back in IDLE.
- Reset asserted on beat 2 of a 5-beat packet -> out_vld/in_rdy=0 asynchronously; after release, port 0 wins first (last_grant=3).
